// File: rtl/btn_conditioner_array.sv
// N-channel button conditioner: 2-flop sync, tick-sampled debounce, press FSM.
// Define BTN_AUTOREPEAT_EN to enable repeat_o pulses while a press is long.
module btn_conditioner_array #(
    parameter int                N_BTN        = 5,
    parameter int                SAMPLE_DIV   = 1000000,
    parameter int                DEB_DEPTH    = 4,
    parameter int                LONG_TICKS   = 100,
    parameter int                REPEAT_TICKS = 20,
    parameter logic [N_BTN-1:0] ACTIVE_LOW   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] short_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] repeat_o
);

    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS);

    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

    logic [DW-1:0]    div;
    logic             tick;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            div   <= tick ? '0 : div + DW'(1);
            sync1 <= btn_i ^ ACTIVE_LOW;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : ch
        // Only DEB_DEPTH-1 history bits are stored; the window adds the new sample.
        logic [DEB_DEPTH-2:0] shreg;
        logic [DEB_DEPTH-1:0] window;
        logic                 rise;
        logic                 fall;
        logic                 level;
        state_t               state;
        logic [HW-1:0]        hold;
        logic                 prs;
        logic                 rls;
        logic                 sht;
        logic                 lng;

        assign window = {shreg, sync2[g]};
        assign rise   = tick & (&window) & ~level;
        assign fall   = tick & ~(|window) & level;

        always_ff @(posedge clk) begin
            if (rst) begin
                shreg <= '0;
                level <= 1'b0;
                state <= IDLE;
                hold  <= '0;
                prs   <= 1'b0;
                rls   <= 1'b0;
                sht   <= 1'b0;
                lng   <= 1'b0;
            end else begin
                prs <= rise;
                rls <= fall;
                sht <= 1'b0;
                lng <= 1'b0;
                if (tick) begin
                    shreg <= window[DEB_DEPTH-2:0];
                    if (&window) level <= 1'b1;
                    else if (~|window) level <= 1'b0;
                end
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= PRESS;
                            hold  <= '0;
                        end
                    end
                    PRESS: begin
                        // A release on the deciding tick wins over long.
                        if (fall) begin
                            sht   <= 1'b1;
                            state <= IDLE;
                        end else if (tick && level) begin
                            hold <= hold + HW'(1);
                            if (hold + HW'(1) == HOLD_LAST) begin
                                lng   <= 1'b1;
                                state <= LONG;
                            end
                        end
                    end
                    LONG: begin
                        if (fall) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign level_o[g]   = level;
        assign press_o[g]   = prs;
        assign release_o[g] = rls;
        assign short_o[g]   = sht;
        assign long_o[g]    = lng;

`ifdef BTN_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_TICKS + 1);
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);

        logic [RW-1:0] rep_cnt;
        logic          rpt;

        // Held at zero outside LONG, so entering LONG starts from a clear count.
        always_ff @(posedge clk) begin
            if (rst) begin
                rep_cnt <= '0;
                rpt     <= 1'b0;
            end else begin
                rpt <= 1'b0;
                if (state != LONG) begin
                    rep_cnt <= '0;
                end else if (tick && !fall) begin
                    if (rep_cnt + RW'(1) == REP_LAST) begin
                        rpt     <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end
            end
        end

        assign repeat_o[g] = rpt;
`else
        assign repeat_o[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_conditioner_array.sv
// Directed bench for btn_conditioner_array: reset, debounce, short/long,
// simultaneous channels and reset mid-hold, with pulse counting per channel.
module tb_btn_conditioner_array;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] short_o;
    logic [N-1:0] long_o;
    logic [N-1:0] repeat_o;

    btn_conditioner_array #(
        .N_BTN       (N),
        .SAMPLE_DIV  (4),
        .DEB_DEPTH   (3),
        .LONG_TICKS  (10),
        .REPEAT_TICKS(4),
        .ACTIVE_LOW  (5'b10000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .short_o  (short_o),
        .long_o   (long_o),
        .repeat_o (repeat_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled 1 time unit after each rising edge.
    logic clr = 1'b0;
    int   cyc = 0;
    int   n_press[N];
    int   n_rel[N];
    int   n_short[N];
    int   n_long[N];
    int   n_rep[N];
    int   n_sr[N];
    int   t_press[N];
    int   t_long[N];
    int   t_rep1[N];
    int   n_all = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (clr) begin
            n_all = 0;
            for (int i = 0; i < N; i++) begin
                n_press[i] = 0;
                n_rel[i]   = 0;
                n_short[i] = 0;
                n_long[i]  = 0;
                n_rep[i]   = 0;
                n_sr[i]    = 0;
                t_press[i] = 0;
                t_long[i]  = 0;
                t_rep1[i]  = -1;
            end
        end else begin
            if (press_o[3:0] == 4'hF) n_all++;
            for (int i = 0; i < N; i++) begin
                if (press_o[i]) begin
                    n_press[i]++;
                    t_press[i] = cyc;
                end
                if (release_o[i]) n_rel[i]++;
                if (short_o[i]) n_short[i]++;
                if (short_o[i] && release_o[i]) n_sr[i]++;
                if (long_o[i]) begin
                    n_long[i]++;
                    t_long[i] = cyc;
                end
                if (repeat_o[i]) begin
                    n_rep[i]++;
                    if (t_rep1[i] < 0) t_rep1[i] = cyc;
                end
            end
        end
    end

    task automatic clear_counts();
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    int d0;

    initial begin
        rst = 1'b1;
        btn = '0;
        wait_clk(3);
        check("rst_level", int'(level_o), 0);
        check("rst_press", int'(press_o), 0);
        check("rst_release", int'(release_o), 0);
        check("rst_short", int'(short_o), 0);
        check("rst_long", int'(long_o), 0);
        check("rst_repeat", int'(repeat_o), 0);
        rst = 1'b0;
        clear_counts();

        // Active-low channel 4 reads as pressed with btn_i[4]=0.
        wait_clk(30);
        check("al_level4", int'(level_o[4]), 1);
        check("al_press4", n_press[4], 1);
        check("al_level30", int'(level_o[3:0]), 0);

        // Debounce latency and glitch rejection on channel 0.
        clear_counts();
        d0 = cyc;
        btn[0] = 1'b1;
        wait_clk(40);
        check("deb_press0", n_press[0], 1);
        check("deb_lat_ok", int'(t_press[0] - d0 >= 11 && t_press[0] - d0 <= 14), 1);
        check("deb_level0", int'(level_o[0]), 1);
        btn[0] = 1'b0;
        wait_clk(5);
        btn[0] = 1'b1;
        wait_clk(30);
        check("glitch_rel0", n_rel[0], 0);
        check("glitch_lvl0", int'(level_o[0]), 1);
        btn[0] = 1'b0;
        wait_clk(30);
        check("held0_rel", n_rel[0], 1);
        check("held0_long", n_long[0], 1);
        check("held0_short", n_short[0], 0);

        // Short press on channel 1.
        clear_counts();
        btn[1] = 1'b1;
        wait_clk(24);
        btn[1] = 1'b0;
        wait_clk(30);
        check("sh_press1", n_press[1], 1);
        check("sh_rel1", n_rel[1], 1);
        check("sh_short1", n_short[1], 1);
        check("sh_same_cyc", n_sr[1], 1);
        check("sh_long1", n_long[1], 0);

        // Long press on channel 2, 34 ticks of hold.
        clear_counts();
        btn[2] = 1'b1;
        wait_clk(136);
        btn[2] = 1'b0;
        wait_clk(30);
        check("lg_long2", n_long[2], 1);
        check("lg_delay", t_long[2] - t_press[2], 40);
        check("lg_rel2", n_rel[2], 1);
        check("lg_short2", n_short[2], 0);
`ifdef BTN_AUTOREPEAT_EN
        check("lg_rep_n", n_rep[2], 5);
        check("lg_rep_1st", t_rep1[2] - t_long[2], 16);
`else
        check("lg_rep_n", n_rep[2], 0);
`endif

        // Simultaneous presses, mixed releases.
        clear_counts();
        btn[3:0] = 4'hF;
        wait_clk(24);
        btn[1:0] = 2'b00;
        wait_clk(36);
        btn[3] = 1'b0;
        wait_clk(40);
        btn[2] = 1'b0;
        wait_clk(30);
        check("sim_press_all", n_all, 1);
        check("sim_short0", n_short[0], 1);
        check("sim_short1", n_short[1], 1);
        check("sim_long01", n_long[0] + n_long[1], 0);
        check("sim_long2", n_long[2], 1);
        check("sim_long3", n_long[3], 1);
        check("sim_short23", n_short[2] + n_short[3], 0);

        // Reset mid-hold on channel 1.
        clear_counts();
        btn[1] = 1'b1;
        wait_clk(34);
        rst = 1'b1;
        wait_clk(2);
        check("mid_rst_lvl", int'(level_o), 0);
        check("mid_rst_pls", int'(press_o | release_o | short_o | long_o), 0);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(30);
        check("mid_press1", n_press[1], 2);
        check("mid_short1", n_short[1], 0);
        check("mid_long1", n_long[1], 0);
        check("mid_rel1", n_rel[1], 0);
        check("mid_level1", int'(level_o[1]), 1);
        check("mid_press4", n_press[4], 1);
        btn[1] = 1'b0;
        wait_clk(30);
        check("mid_after_sh", n_short[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
